// File: rtl/npu_agu_pkg.sv
// Shared definitions for the NPU address generators: FSM encoding, widths,
// and the weight address helper.
package npu_agu_pkg;

    localparam int AGU_AW = 12;
    localparam int AGU_WW = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SYNC = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } agu_state_e;

    // base + op*W + idx, wrapped to the weight buffer size
    function automatic logic [AGU_AW-1:0] agu_addr(
        input logic [AGU_AW-1:0] base,
        input logic [7:0]        op,
        input logic [AGU_WW-1:0] w_len,
        input logic [AGU_WW-1:0] idx
    );
        return AGU_AW'({16'd0, op} * {8'd0, w_len} + {8'd0, idx} + {12'd0, base});
    endfunction

endpackage

// File: rtl/wagu_loop_cnt.sv
// Nested weight-load counters: idx within one output piece, op over output
// pieces, part over tiling parts.
module wagu_loop_cnt
    import npu_agu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_idx_inc,
    input  logic              i_idx_clr,
    input  logic              i_op_inc,
    input  logic [AGU_WW-1:0] i_w_len,
    input  logic [7:0]        i_out_piece,
    input  logic [4:0]        i_part_num,
    output logic [AGU_WW-1:0] o_idx,
    output logic [7:0]        o_op,
    output logic [7:0]        o_op_nxt,
    output logic              o_idx_last,
    output logic              o_op_last,
    output logic              o_part_last
);

    logic [4:0] r_part;

    assign o_idx_last  = ({1'b0, o_idx} + 17'd1) == {1'b0, i_w_len};
    assign o_op_last   = ({1'b0, o_op} + 9'd1) >= {1'b0, i_out_piece};
    assign o_part_last = ({1'b0, r_part} + 6'd1) >= {1'b0, i_part_num};
    assign o_op_nxt    = o_op_last ? 8'd0 : o_op + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_idx  <= '0;
            o_op   <= '0;
            r_part <= '0;
        end else if (i_clr) begin
            o_idx  <= '0;
            o_op   <= '0;
            r_part <= '0;
        end else begin
            if (i_idx_clr)
                o_idx <= '0;
            else if (i_idx_inc)
                o_idx <= o_idx + 16'd1;
            if (i_op_inc) begin
                o_op <= o_op_nxt;
                if (o_op_last)
                    r_part <= o_part_last ? 5'd0 : r_part + 5'd1;
            end
        end
    end

endmodule

// File: rtl/weight_agu.sv
// Weight buffer address generator: streams K*K*in_piece weights per output
// piece, handshaking with the feature AGU. Define WAGU_PROTO_CHECK_EN for the
// sticky protocol-error flag.
module weight_agu
    import npu_agu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calculate,
    input  logic              i_feature_end,
    input  logic [AGU_AW-1:0] addr_start_w,
    input  logic [3:0]        i_kernel,
    input  logic [7:0]        in_piece,
    input  logic [7:0]        out_piece,
    input  logic [4:0]        part_num,
    output logic [AGU_AW-1:0] o_w_addr,
    output logic              o_w_rd_en,
    output logic              o_weight_load_end,
    output logic              o_calc_done,
    output logic              o_proto_err
);

    agu_state_e        r_state;
    logic [AGU_AW-1:0] r_base;
    logic [AGU_WW-1:0] r_w_len;
    logic [7:0]        r_out_piece;
    logic [4:0]        r_part_num;

    logic [AGU_WW-1:0] w_w_len_in, w_idx;
    logic [7:0]        w_op, w_op_nxt;
    logic              w_idx_last, w_op_last, w_part_last;
    logic              w_start, w_load_fin, w_fe;

    assign w_w_len_in = {12'd0, i_kernel} * {12'd0, i_kernel} * {8'd0, in_piece};
    assign w_start    = (r_state == ST_IDLE) && start_calculate;
    assign w_load_fin = (r_state == ST_LOAD) && ((r_w_len == '0) || w_idx_last);
    assign w_fe       = (r_state == ST_WAIT) && i_feature_end;

    wagu_loop_cnt u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_idx_inc   ((r_state == ST_LOAD) && !w_load_fin),
        .i_idx_clr   (w_load_fin),
        .i_op_inc    (w_fe),
        .i_w_len     (r_w_len),
        .i_out_piece (r_out_piece),
        .i_part_num  (r_part_num),
        .o_idx       (w_idx),
        .o_op        (w_op),
        .o_op_nxt    (w_op_nxt),
        .o_idx_last  (w_idx_last),
        .o_op_last   (w_op_last),
        .o_part_last (w_part_last)
    );

    // Outputs are registered together with the transition, so the state a
    // cycle is in and its strobes always line up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_base            <= '0;
            r_w_len           <= '0;
            r_out_piece       <= '0;
            r_part_num        <= '0;
            o_w_addr          <= '0;
            o_w_rd_en         <= 1'b0;
            o_weight_load_end <= 1'b0;
            o_calc_done       <= 1'b0;
        end else begin
            o_w_rd_en         <= 1'b0;
            o_weight_load_end <= 1'b0;
            o_calc_done       <= 1'b0;
            case (r_state)
                ST_IDLE: if (start_calculate) begin
                    r_base      <= addr_start_w;
                    r_w_len     <= w_w_len_in;
                    r_out_piece <= out_piece;
                    r_part_num  <= part_num;
                    if (out_piece == 8'd0 || part_num == 5'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state   <= ST_LOAD;
                        o_w_rd_en <= (w_w_len_in != '0);
                        o_w_addr  <= addr_start_w;
                    end
                end
                ST_LOAD: if (w_load_fin) begin
                    r_state           <= ST_SYNC;
                    o_weight_load_end <= 1'b1;
                end else begin
                    o_w_rd_en <= 1'b1;
                    o_w_addr  <= agu_addr(r_base, w_op, r_w_len, w_idx + 16'd1);
                end
                ST_SYNC: r_state <= ST_WAIT;
                ST_WAIT: if (i_feature_end) begin
                    if (w_op_last && w_part_last) begin
                        r_state     <= ST_DONE;
                        o_calc_done <= 1'b1;
                    end else begin
                        r_state   <= ST_LOAD;
                        o_w_rd_en <= (r_w_len != '0);
                        o_w_addr  <= agu_addr(r_base, w_op_nxt, r_w_len, 16'd0);
                    end
                end
                // An empty layer enters DONE without its pulse; it fires on
                // the following cycle, two cycles after start.
                ST_DONE: if (o_calc_done) r_state <= ST_IDLE;
                         else o_calc_done <= 1'b1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef WAGU_PROTO_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            o_proto_err <= 1'b0;
        else if ((i_feature_end && r_state != ST_WAIT) ||
                 (start_calculate && r_state != ST_IDLE))
            o_proto_err <= 1'b1;
    end
`else
    assign o_proto_err = 1'b0;
`endif

    // Only the WAIT-state view of i_feature_end drives the counters.
    logic w_unused_fe;
    assign w_unused_fe = w_fe;

endmodule
